// File: rtl/cache_fill_fsm.sv
// Purpose: miss-fill sequencer for a 128-set x 8-word x 16-bit direct-mapped cache data/tag array.
// Latency: stall starts combinationally in the miss cycle; 8 reads in cycles 1..8; fill_done with the 8th returned word.
// Backpressure: none on either side; memory takes one read per cycle, returned words are written the cycle they arrive.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   miss_detected, miss_address   miss request from the hit logic (byte address)
//   memory_data_valid/_data       in-order word return stream from main memory
//   fsm_busy                      pipeline stall request
//   memory_read, memory_address   read request stream to memory
//   write_data_array, block_enable, word_enable, data_out   data array write port
//   write_tag_array, fill_done    tag/valid write strobe and completion pulse
module cache_fill_fsm (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_detected,
    input  logic [15:0]  miss_address,
    input  logic         memory_data_valid,
    input  logic [15:0]  memory_data,
    output logic         fsm_busy,
    output logic         memory_read,
    output logic [15:0]  memory_address,
    output logic         write_data_array,
    output logic [127:0] block_enable,
    output logic [7:0]   word_enable,
    output logic [15:0]  data_out,
    output logic         write_tag_array,
    output logic         fill_done
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [11:0] base_addr, base_nx;   // byte address bits [15:4] of the block being filled
    logic [3:0]  issue_cnt, issue_nx;  // reads issued so far, 0..8
    logic [2:0]  recv_cnt, recv_nx;    // words written so far, 0..7
    logic [6:0]  set_idx;

    // base_addr holds addr[15:4], so the set index addr[10:4] is its low 7 bits.
    assign set_idx = base_addr[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_addr <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nx;
            base_addr <= base_nx;
            issue_cnt <= issue_nx;
            recv_cnt  <= recv_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        base_nx          = base_addr;
        issue_nx         = issue_cnt;
        recv_nx          = recv_cnt;
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        block_enable     = '0;
        word_enable      = '0;
        data_out         = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        case (state)
            IDLE: begin
                // Returned words arriving here belong to a fill aborted by reset: dropped.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_nx  = miss_address[15:4];
                    issue_nx = '0;
                    recv_nx  = '0;
                    state_nx = FILL;
                end
            end
            FILL: begin
                // New misses are ignored here; the stalled pipeline re-presents them afterwards.
                fsm_busy = 1'b1;
                if (issue_cnt < 4'd8) begin
                    memory_read    = 1'b1;
                    memory_address = {base_addr, issue_cnt[2:0], 1'b0};
                    issue_nx       = issue_cnt + 4'd1;
                end
                // Only accept a word when a request is outstanding; a stray valid is ignored.
                if (memory_data_valid && (issue_cnt > {1'b0, recv_cnt})) begin
                    write_data_array = 1'b1;
                    block_enable     = 128'd1 << set_idx;
                    word_enable      = 8'd1 << recv_cnt;
                    data_out         = memory_data;
                    recv_nx          = recv_cnt + 3'd1;
                    if (recv_cnt == 3'd7) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_nx        = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // All outputs, including the combinational stall, read 0 while reset is held.
        if (rst) begin
            fsm_busy = 1'b0;
        end
    end

endmodule
